// File: rtl/usb_line_tx.sv
// usb_line_tx: USB low/full-speed line transmitter.
// Takes packet bytes over a valid/ready handshake. It sends SYNC, then the
// NRZI-encoded and bit-stuffed data (optionally followed by CRC16), then EOP.
// Optional CRC16 generation is enabled by defining USB_LINE_TX_CRC16_EN.
//
// Parameters
//   FULLSPEED    : 1 = J is dp=1/dm=0, 0 = J is dp=0/dm=1
//   CLKS_PER_BIT : clk cycles per USB bit time (2..255)
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   tx_data/valid/last    : byte stream in, LSB first, last marks final byte
//   tx_crc16              : request CRC16, sampled with the first byte only
//   tx_ready              : byte accepted on valid & ready
//   tx_busy               : packet in progress
//   tx_err                : one-cycle pulse on underrun abort
//   dp_out, dm_out        : driven line levels
//   line_oe               : line driver enable
module usb_line_tx #(
  parameter int FULLSPEED    = 1,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  input  logic       tx_crc16,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_err,
  output logic       dp_out,
  output logic       dm_out,
  output logic       line_oe
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, CRC, EOP_SE0, EOP_J} state_t;

  localparam logic [7:0] TMAX = 8'(CLKS_PER_BIT - 1);
  localparam logic       J_DP = (FULLSPEED != 0);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] shift_q, shift_d;     // shift_q[0] is the bit on the line
  logic [2:0] bitn_q, bitn_d;
  logic [2:0] ones_q, ones_d;
  logic       line_k_q, line_k_d;   // 1 = K, 0 = J
  logic       se0_q, se0_d;
  logic       oe_q, oe_d;
  logic       err_q, err_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       hold_last_q, hold_last_d;
  logic       cur_last_q, cur_last_d;
  logic       last_seen_q, last_seen_d;
  logic       rdy_en_q;

  logic xfer, wrap, emit, nbit;

`ifdef USB_LINE_TX_CRC16_EN
  logic [15:0] crc_q, crc_d, crc_upd;
  logic        crc_req_q, crc_req_d;
  logic        crc_hi_q, crc_hi_d;

  // Reflected x^16+x^15+x^2+1, fed with the data bit leaving the shifter.
  assign crc_upd = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ shift_q[0]) ? 16'hA001 : 16'h0000);
`else
  logic unused_crc16;
  assign unused_crc16 = tx_crc16;
`endif

  assign tx_ready = rdy_en_q & ~hold_full_q & ~last_seen_q &
                    (state_q != EOP_SE0) & (state_q != EOP_J);
  assign xfer     = tx_valid & tx_ready;
  assign wrap     = (timer_q == TMAX);
  assign tx_busy  = (state_q != IDLE);
  assign tx_err   = err_q;
  assign line_oe  = oe_q;
  assign dp_out   = ~se0_q & (line_k_q ^ J_DP);
  assign dm_out   = ~se0_q & ~(line_k_q ^ J_DP);

  always_comb begin
    state_d     = state_q;
    timer_d     = wrap ? '0 : timer_q + 8'd1;
    shift_d     = shift_q;
    bitn_d      = bitn_q;
    ones_d      = ones_q;
    line_k_d    = line_k_q;
    se0_d       = se0_q;
    oe_d        = oe_q;
    err_d       = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    hold_last_d = hold_last_q;
    cur_last_d  = cur_last_q;
    last_seen_d = last_seen_q;
    emit        = 1'b0;
    nbit        = 1'b0;
`ifdef USB_LINE_TX_CRC16_EN
    crc_d       = crc_q;
    crc_req_d   = crc_req_q;
    crc_hi_d    = crc_hi_q;
`endif

    if (xfer) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      hold_last_d = tx_last;
      last_seen_d = last_seen_q | tx_last;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (xfer) begin
          state_d = SYNC;
          shift_d = 8'h80;
          bitn_d  = '0;
          oe_d    = 1'b1;
          emit    = 1'b1;
`ifdef USB_LINE_TX_CRC16_EN
          crc_req_d = tx_crc16;
          crc_d     = '1;
`endif
        end
      end

      SYNC, DATA, CRC: if (wrap) begin
        // A stuff bit leaves the bit pointer in place; the bit it follows
        // is only retired on the next wrap, so a stuff bit due after the
        // final bit still goes out before EOP.
        if (ones_q == 3'd6) begin
          emit = 1'b1;
        end else if (bitn_q != 3'd7) begin
`ifdef USB_LINE_TX_CRC16_EN
          if (state_q == DATA) crc_d = crc_upd;
`endif
          shift_d = {1'b0, shift_q[7:1]};
          bitn_d  = bitn_q + 3'd1;
          emit    = 1'b1;
          nbit    = shift_q[1];
        end else begin
          bitn_d = '0;
`ifdef USB_LINE_TX_CRC16_EN
          if (state_q == DATA) crc_d = crc_upd;
`endif
          if (state_q == SYNC || (state_q == DATA && !cur_last_q)) begin
            if (hold_full_q || xfer) begin
              // A byte offered exactly at the boundary goes straight in.
              shift_d     = hold_full_q ? hold_q : tx_data;
              cur_last_d  = hold_full_q ? hold_last_q : tx_last;
              hold_full_d = 1'b0;
              state_d     = DATA;
              emit        = 1'b1;
              nbit        = shift_d[0];
            end else begin
              state_d     = EOP_SE0;
              se0_d       = 1'b1;
              err_d       = 1'b1;
              last_seen_d = 1'b0;
              hold_full_d = 1'b0;
            end
          end
`ifdef USB_LINE_TX_CRC16_EN
          else if (state_q == DATA && crc_req_q) begin
            state_d  = CRC;
            shift_d  = ~crc_upd[7:0];
            crc_hi_d = 1'b0;
            emit     = 1'b1;
            nbit     = shift_d[0];
          end else if (state_q == CRC && !crc_hi_q) begin
            shift_d  = ~crc_q[15:8];
            crc_hi_d = 1'b1;
            emit     = 1'b1;
            nbit     = shift_d[0];
          end
`endif
          else begin
            state_d = EOP_SE0;
            se0_d   = 1'b1;
          end
        end
      end

      EOP_SE0: if (wrap) begin
        if (bitn_q == 3'd1) begin
          state_d  = EOP_J;
          se0_d    = 1'b0;
          line_k_d = 1'b0;
        end else begin
          bitn_d = 3'd1;
        end
      end

      EOP_J: if (wrap) begin
        state_d     = IDLE;
        oe_d        = 1'b0;
        line_k_d    = 1'b0;
        last_seen_d = 1'b0;
        hold_full_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase

    // NRZI: 0 toggles the line, 1 holds it; any 0 clears the ones run.
    if (emit) begin
      ones_d   = nbit ? ones_q + 3'd1 : '0;
      line_k_d = nbit ? line_k_q : ~line_k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      shift_q     <= '0;
      bitn_q      <= '0;
      ones_q      <= '0;
      line_k_q    <= 1'b0;
      se0_q       <= 1'b0;
      oe_q        <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      cur_last_q  <= 1'b0;
      last_seen_q <= 1'b0;
      rdy_en_q    <= 1'b0;
`ifdef USB_LINE_TX_CRC16_EN
      crc_q       <= '0;
      crc_req_q   <= 1'b0;
      crc_hi_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      bitn_q      <= bitn_d;
      ones_q      <= ones_d;
      line_k_q    <= line_k_d;
      se0_q       <= se0_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      hold_last_q <= hold_last_d;
      cur_last_q  <= cur_last_d;
      last_seen_q <= last_seen_d;
      rdy_en_q    <= 1'b1;
`ifdef USB_LINE_TX_CRC16_EN
      crc_q       <= crc_d;
      crc_req_q   <= crc_req_d;
      crc_hi_q    <= crc_hi_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_line_tx.sv
// tb_usb_line_tx: directed bench for usb_line_tx (CLKS_PER_BIT=4).
// One full-speed and one low-speed instance share the stimulus; use_ls picks
// which one receives tx_valid and which one is observed.
module tb_usb_line_tx;
  localparam int CPB = 4;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_crc16;
  logic       use_ls;
  logic       fs_valid, ls_valid;
  logic       fs_ready, fs_busy, fs_err, fs_dp, fs_dm, fs_oe;
  logic       ls_ready, ls_busy, ls_err, ls_dp, ls_dm, ls_oe;
  logic       m_ready, m_busy, m_err, m_dp, m_dm, m_oe;

  int          n_cmp, n_bad;
  string       syms;
  int          oe_cyc, err_cnt, err_idx;
  int          waits[3];
  logic [7:0]  dec[$];
  logic [7:0]  sync_v;
  logic [23:0] dec_pk;
  int          dec_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fs_valid = tx_valid & ~use_ls;
  assign ls_valid = tx_valid & use_ls;
  assign m_ready  = use_ls ? ls_ready : fs_ready;
  assign m_busy   = use_ls ? ls_busy  : fs_busy;
  assign m_err    = use_ls ? ls_err   : fs_err;
  assign m_dp     = use_ls ? ls_dp    : fs_dp;
  assign m_dm     = use_ls ? ls_dm    : fs_dm;
  assign m_oe     = use_ls ? ls_oe    : fs_oe;

  usb_line_tx #(.FULLSPEED(1), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(fs_valid),
    .tx_last(tx_last), .tx_crc16(tx_crc16), .tx_ready(fs_ready),
    .tx_busy(fs_busy), .tx_err(fs_err), .dp_out(fs_dp), .dm_out(fs_dm),
    .line_oe(fs_oe)
  );

  usb_line_tx #(.FULLSPEED(0), .CLKS_PER_BIT(CPB)) dut_ls (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(ls_valid),
    .tx_last(tx_last), .tx_crc16(tx_crc16), .tx_ready(ls_ready),
    .tx_busy(ls_busy), .tx_err(ls_err), .dp_out(ls_dp), .dm_out(ls_dm),
    .line_oe(ls_oe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string got, input string exp);
    n_cmp++;
    assert (got == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %s expected %s", tag, got, exp);
    end
  endtask

  // Offers n bytes (byte i in bytes[8i+:8]); tx_crc16 is inverted after the
  // first byte so a design that re-samples it is exposed.
  task automatic send_pkt(input int n, input logic [23:0] bytes, input logic crc,
                          input logic with_last);
    int w;
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1;
      tx_data  = bytes[8*i +: 8];
      tx_last  = with_last && (i == n - 1);
      tx_crc16 = (i == 0) ? crc : ~crc;
      w = 0;
      while (!m_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      waits[i] = w;
      chk("ready_for_byte", 32'(m_ready), 32'd1);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_crc16 = 1'b0;
  endtask

  // Records one symbol per bit time while line_oe is high.
  task automatic capture();
    int n, cyc;
    syms = ""; oe_cyc = 0; err_cnt = 0; err_idx = -1;
    n = 0;
    while (!m_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("oe_rise", 32'(m_oe), 32'd1);
    cyc = 0;
    while (m_oe && cyc < 400) begin
      if (cyc % CPB == 1) begin
        if (!m_dp && !m_dm)                          syms = {syms, "0"};
        else if (m_dp == !use_ls && m_dm == use_ls)  syms = {syms, "J"};
        else if (m_dp == use_ls && m_dm == !use_ls)  syms = {syms, "K"};
        else                                         syms = {syms, "X"};
      end
      if (m_err) begin
        err_cnt++;
        err_idx = cyc;
      end
      cyc++;
      @(negedge clk);
    end
    oe_cyc = cyc;
    chk("oe_fall", 32'(m_oe), 32'd0);
  endtask

  // NRZI-decodes and destuffs the captured symbols (SYNC included).
  task automatic decode();
    byte c, prev;
    int ones, nb, k;
    logic b;
    logic [7:0] cur;
    dec.delete();
    prev = "J"; ones = 0; nb = 0; cur = '0; sync_v = '0;
    for (int i = 0; i < syms.len(); i++) begin
      c = syms[i];
      if (c != "J" && c != "K") break;
      b = (c == prev);
      prev = c;
      if (ones == 6) begin
        ones = 0;
        continue;
      end
      ones = b ? ones + 1 : 0;
      if (nb < 8) sync_v[nb] = b;
      else begin
        k = (nb - 8) % 8;
        cur[k] = b;
        if (k == 7) dec.push_back(cur);
      end
      nb++;
    end
    dec_n  = dec.size();
    dec_pk = '0;
    for (int i = 0; i < 3 && i < dec_n; i++) dec_pk[8*i +: 8] = dec[i];
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    tx_crc16 = 1'b0; use_ls = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_oe",    32'(fs_oe),    32'd0);
    chk("rst_dp",    32'(fs_dp),    32'd1);
    chk("rst_dm",    32'(fs_dm),    32'd0);
    chk("rst_busy",  32'(fs_busy),  32'd0);
    chk("rst_err",   32'(fs_err),   32'd0);
    chk("rst_ready", 32'(fs_ready), 32'd0);
    chk("ls_rst_dp", 32'(ls_dp),    32'd0);
    chk("ls_rst_dm", 32'(ls_dm),    32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(fs_ready), 32'd1);

    // V1: 0x00
    fork
      send_pkt(1, 24'h000000, 1'b0, 1'b1);
      capture();
    join
    decode();
    chk("v1_oe_cycles", 32'(oe_cyc), 32'd76);
    chk_s("v1_line", syms, "KJKJKJKKJKJKJKJK00J");
    chk("v1_sync", 32'(sync_v), 32'h80);
    chk("v1_nbytes", 32'(dec_n), 32'd1);
    chk("v1_byte", 32'(dec_pk), 32'h000000);
    chk("v1_err", 32'(err_cnt), 32'd0);
    chk("v1_idle_busy", 32'(fs_busy), 32'd0);
    chk("v1_idle_ready", 32'(fs_ready), 32'd1);

    // V2: 0xFF with a stuff bit
    fork
      send_pkt(1, 24'h0000FF, 1'b0, 1'b1);
      capture();
    join
    decode();
    chk("v2_oe_cycles", 32'(oe_cyc), 32'd80);
    chk_s("v2_line", syms, "KJKJKJKKKKKKKJJJJ00J");
    chk("v2_byte", 32'(dec_pk), 32'h0000FF);

    // V3: 0x3C then underrun
    fork
      send_pkt(1, 24'h00003C, 1'b0, 1'b0);
      capture();
    join
    decode();
    chk("v3_oe_cycles", 32'(oe_cyc), 32'd76);
    chk_s("v3_line", syms, "KJKJKJKKJKKKKKJK00J");
    chk("v3_err_count", 32'(err_cnt), 32'd1);
    chk("v3_err_cycle", 32'(err_idx), 32'd64);
    chk("v3_idle_busy", 32'(fs_busy), 32'd0);
    chk("v3_idle_ready", 32'(fs_ready), 32'd1);

    // V4: reset during 4th data bit of 0xA5
    send_pkt(1, 24'h0000A5, 1'b0, 1'b1);
    repeat (45) @(negedge clk);
    chk("v4_mid_oe", 32'(fs_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("v4_oe",    32'(fs_oe),    32'd0);
    chk("v4_dp",    32'(fs_dp),    32'd1);
    chk("v4_dm",    32'(fs_dm),    32'd0);
    chk("v4_busy",  32'(fs_busy),  32'd0);
    chk("v4_ready", 32'(fs_ready), 32'd0);
    @(negedge clk);
    chk("v4_ready_after", 32'(fs_ready), 32'd1);

    // V5: 0x00 with CRC16 requested
    fork
      send_pkt(1, 24'h000000, 1'b1, 1'b1);
      capture();
    join
    decode();
`ifdef USB_LINE_TX_CRC16_EN
    chk("v5_nbytes", 32'(dec_n), 32'd3);
    chk("v5_bytes", 32'(dec_pk), 32'hBF4000);
    chk("v5_oe_cycles", 32'(oe_cyc), 32'd144);
`else
    chk("v5_nbytes", 32'(dec_n), 32'd1);
    chk("v5_bytes", 32'(dec_pk), 32'h000000);
    chk("v5_oe_cycles", 32'(oe_cyc), 32'd76);
`endif

    // V6: low speed, three back-to-back bytes
    use_ls = 1'b1;
    @(negedge clk);
    chk("v6_idle_dp", 32'(m_dp), 32'd0);
    chk("v6_idle_dm", 32'(m_dm), 32'd1);
    fork
      send_pkt(3, 24'h030201, 1'b0, 1'b1);
      capture();
    join
    decode();
    chk("v6_oe_cycles", 32'(oe_cyc), 32'd140);
    chk("v6_nbytes", 32'(dec_n), 32'd3);
    chk("v6_bytes", 32'(dec_pk), 32'h030201);
    chk("v6_sync", 32'(sync_v), 32'h80);
    chk("v6_wait_byte1", 32'(waits[1]), 32'd32);
    chk("v6_wait_byte2", 32'(waits[2]), 32'd31);
    chk("v6_idle_busy", 32'(m_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usb_line_tx.md
USB_LINE_TX -- requirements
Module: usb_line_tx

Interface
REQ-001 The block SHALL use one clock and one reset: the reset is synchronous and active-high.
REQ-002 Parameter FULLSPEED, default 1, SHALL set the line polarity: 1 = full speed (J is dp=1/dm=0), 0 = low speed (J is dp=0/dm=1).
REQ-003 Parameter CLKS_PER_BIT, default 4, SHALL set the clk cycles per USB bit time; legal values are 2 to 255.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port tx_data, input, 8: packet byte, sent LSB first.
REQ-007 Port tx_valid, input, 1: tx_data is valid.
REQ-008 Port tx_last, input, 1: the current byte is the final packet byte.
REQ-009 Port tx_crc16, input, 1: append CRC16; sampled with the first byte only.
REQ-010 Port tx_ready, output, 1: the block accepts a byte this cycle.
REQ-011 Port tx_busy, output, 1: a packet is in progress.
REQ-012 Port tx_err, output, 1: one-cycle pulse on underrun abort.
REQ-013 Port dp_out, output, 1: driven D+ level.
REQ-014 Port dm_out, output, 1: driven D- level.
REQ-015 Port line_oe, output, 1: line driver enable.

Function
REQ-016 A byte transfer SHALL occur on a rising edge where tx_valid and tx_ready are both 1.
REQ-017 tx_ready SHALL be 1 when the one-byte holding register is empty, tx_last has not been accepted in the current packet, and the state is not EOP_SE0 or EOP_J.
REQ-018 The bit timer SHALL count 0..CLKS_PER_BIT-1 and wrap; dp_out/dm_out SHALL change only at wrap, except on the first SYNC bit.
REQ-019 States: IDLE, SYNC, DATA, CRC, EOP_SE0, EOP_J.
- IDLE -> SYNC on the first accepted byte.
- SYNC -> DATA after 8 bits.
- DATA -> CRC when the last byte has been shifted and CRC16 is requested.
- DATA/CRC -> EOP_SE0 when the packet is done.
- EOP_SE0 -> EOP_J after 2 bits.
- EOP_J -> IDLE after 1 bit.
REQ-020 In IDLE, line_oe=0, dp_out/dm_out=J and tx_busy=0; line_oe and tx_busy SHALL assert on the cycle after the first byte is accepted, with the first SYNC bit (K) driven in that same cycle.
REQ-021 SYNC SHALL be the bit pattern 0000_0001 sent NRZI, giving the line sequence KJKJKJKK.
REQ-022 NRZI encoding SHALL be: a 0 bit toggles J/K, a 1 bit holds the current state.
REQ-023 Bit stuffing SHALL insert a 0 bit after six consecutive 1 bits.
- The ones counter spans SYNC, DATA and CRC.
- Any 0 bit, stuffed or not, clears the counter.
- A stuff bit due after the final bit SHALL be sent before EOP.
REQ-024 The shifter SHALL reload from the holding register at the byte boundary with no idle bit times.
REQ-025 If the holding register is empty at a byte boundary before tx_last has been seen, the block SHALL:
- abort to EOP_SE0;
- pulse tx_err for 1 cycle;
- drop any partially accepted packet.
REQ-026 EOP SHALL drive SE0 (dp=0, dm=0) for 2 bit times, then J for 1 bit time; line_oe SHALL deassert on the cycle after EOP_J ends.
REQ-027 While tx_busy is 1, tx_crc16 SHALL be ignored on all bytes after the first.
REQ-028 A new packet's first byte SHALL NOT be accepted before IDLE is re-entered; there is no minimum gap beyond that.

Reset
REQ-029 On reset=1 at a clock edge, mid-packet included, the block SHALL apply these values from the next cycle:
- state=IDLE, holding register empty;
- line_oe=0, dp_out/dm_out=J;
- tx_ready=0, tx_busy=0, tx_err=0;
- bit timer, stuff counter and CRC all cleared.
REQ-030 tx_ready SHALL assert on the first cycle after reset deasserts.

Configuration
REQ-031 Macro USB_LINE_TX_CRC16_EN SHALL control CRC16 generation.
REQ-032 With USB_LINE_TX_CRC16_EN defined, a packet whose first byte had tx_crc16=1 SHALL carry a 16-bit CRC after its last byte, as follows:
- computed over all data bits;
- polynomial x^16+x^15+x^2+1;
- initial value 0xFFFF, LSB first;
- complemented before transmission;
- sent low byte first, bit-stuffed.
REQ-033 Without the macro, tx_crc16 SHALL be ignored, the CRC state SHALL never be entered, and no CRC logic SHALL be synthesised.

Verification
REQ-034 The bench SHALL cover these directed scenarios (CLKS_PER_BIT=4, FULLSPEED=1):
- V1: byte 0x00, tx_last=1 -> line_oe high for 76 clocks; lines KJKJKJKK, then 8 alternating J/K bits, then SE0 SE0 J; then IDLE.
- V2: byte 0xFF, tx_last=1 -> a stuff bit after data bit 5; 20 bit times (80 clocks) with line_oe high.
- V3: byte 0x3C, then tx_valid low at the next byte boundary with tx_last not yet seen -> tx_err pulses once; EOP follows the 8th data bit; back in IDLE 3 bit times later.
- V4: reset=1 for 1 cycle during the 4th data bit of 0xA5 -> line_oe=0 and dp_out/dm_out=1/0 next cycle; tx_ready=1 the cycle after reset drops.
- V5: macro defined, byte 0x00 with tx_crc16=1 and tx_last=1 -> decoded data bytes are 0x00, 0x40, 0xBF; without the macro, only 0x00 is sent.
- V6: FULLSPEED=0, three back-to-back bytes 0x01 0x02 0x03 -> J is dp=0/dm=1; the bytes are sent with no gap between them; tx_ready is held no longer than 1 byte time.
